// File: rtl/bird_input_ctrl_if.sv
// Control bundle between bird_input_ctrl and the game/display side.
//   key_raw   : raw flap key from the board pin (asynchronous)
//   game_over : collision/game-over level from the game logic
//   tick      : one-cycle enable to the bird-column light cells
//   up        : flap level to the light cells
//   dead      : high while the controller is in its DEAD state
//   flaps     : saturating count of accepted presses
interface bird_input_ctrl_if;
  logic       key_raw;
  logic       game_over;
  logic       tick;
  logic       up;
  logic       dead;
  logic [7:0] flaps;

  // Game/board side: drives the key and game-over flag, observes outputs.
  modport master (
    output key_raw,
    output game_over,
    input  tick,
    input  up,
    input  dead,
    input  flaps
  );

  // Controller side.
  modport slave (
    input  key_raw,
    input  game_over,
    output tick,
    output up,
    output dead,
    output flaps
  );
endinterface

// File: rtl/bird_input_ctrl.sv
// Upstream control stage for the bird column: divides clk into a one-cycle
// tick, synchronises and edge-detects the flap key, and holds `up` for a
// fixed number of ticks per accepted press.
//   clk   : system clock
//   reset : synchronous, active-high
//   ctl   : slave side of bird_input_ctrl_if (key_raw, game_over in;
//           tick, up, dead, flaps out)
module bird_input_ctrl #(
  parameter int unsigned TICK_DIV       = 25_000_000,
  parameter int unsigned FLAP_TICKS     = 2,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  bird_input_ctrl_if.slave  ctl
);

  localparam int unsigned CNT_W   = $clog2(TICK_DIV);
  localparam int unsigned RISE_W  = $clog2(FLAP_TICKS + 1);
  localparam int unsigned FLAPS_W = 8;

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [RISE_W-1:0]  RISE_LOAD = RISE_W'(FLAP_TICKS);
  localparam logic [RISE_W-1:0]  RISE_ONE  = RISE_W'(1);
  localparam logic [FLAPS_W-1:0] FLAPS_MAX = FLAPS_W'(255);
  localparam logic               KEY_REL   = KEY_ACTIVE_LOW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  logic               s1_q, s2_q;
  logic               key_prev_q, key_prev_d;
  logic [1:0]         fill_q;
  logic               key_s_c;
  logic               press_c;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_c;

  logic [1:0]         state_q, state_d;
  logic [RISE_W-1:0]  rise_q, rise_d;
  logic [FLAPS_W-1:0] flaps_q, flaps_d;
  logic               up_q, up_d;
  logic               dead_q, dead_d;

  // Key synchroniser and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= KEY_REL;
      s2_q       <= KEY_REL;
      key_prev_q <= 1'b1;
      fill_q     <= 2'b00;
    end else begin
      s1_q       <= ctl.key_raw;
      s2_q       <= s1_q;
      key_prev_q <= key_prev_d;
      fill_q     <= {fill_q[0], 1'b1};
    end
  end

  // Normalised key: 1 means pressed.
  assign key_s_c = s2_q ^ KEY_REL;

  // key_prev stays 1 until the synchroniser has flushed its reset value, so
  // a key held through reset never looks like a fresh edge.
  assign key_prev_d = fill_q[1] ? key_s_c : 1'b1;
  assign press_c    = key_s_c & ~key_prev_q;

  // Free-running tick divider.
  assign cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  assign tick_c = (cnt_q == CNT_MAX) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flap FSM state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rise_q  <= '0;
      flaps_q <= '0;
      up_q    <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      flaps_q <= flaps_d;
      up_q    <= up_d;
      dead_q  <= dead_d;
    end
  end

  // Next-state logic; game_over outranks press and tick.
  always_comb begin
    state_d = state_q;
    rise_d  = rise_q;
    flaps_d = flaps_q;

    if (ctl.game_over) begin
      state_d = ST_DEAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_c) begin
            state_d = ST_RISE;
            rise_d  = RISE_LOAD;
            flaps_d = (flaps_q == FLAPS_MAX) ? flaps_q : flaps_q + FLAPS_W'(1);
          end
        end
        ST_RISE: begin
          // A press in a tick cycle reloads; the tick is not consumed.
          if (press_c) begin
            rise_d  = RISE_LOAD;
            flaps_d = (flaps_q == FLAPS_MAX) ? flaps_q : flaps_q + FLAPS_W'(1);
          end else if (tick_c) begin
            if (rise_q == RISE_ONE) begin
              state_d = ST_IDLE;
              rise_d  = '0;
            end else begin
              rise_d = rise_q - RISE_W'(1);
            end
          end
        end
        ST_DEAD: begin
          state_d = ST_DEAD;
        end
        default: begin
          state_d = ST_IDLE;
          rise_d  = '0;
        end
      endcase
    end

    up_d   = (state_d == ST_RISE);
    dead_d = (state_d == ST_DEAD);
  end

  assign ctl.tick  = tick_c;
  assign ctl.up    = up_q;
  assign ctl.dead  = dead_q;
  assign ctl.flaps = flaps_q;

endmodule
